// File: rtl/tetris_vga_pkg.sv
// Shared VGA timing, grid geometry, colour and vertical-state constants for the
// renderer and the game/storage side of the grid.
package tetris_vga_pkg;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned H_FP     = 16;
  localparam int unsigned H_SYNC   = 96;
  localparam int unsigned H_BP     = 48;
  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned V_FP     = 10;
  localparam int unsigned V_SYNC_L = 2;
  localparam int unsigned V_BP     = 33;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC_L + V_BP;

  localparam int unsigned GRID_W   = 9;
  localparam int unsigned GRID_H   = 16;
  localparam int unsigned CELL_PX  = 24;
  localparam int unsigned X0       = 212;
  localparam int unsigned Y0       = 48;
  localparam int unsigned X_END    = X0 + GRID_W * CELL_PX;
  localparam int unsigned Y_END    = Y0 + GRID_H * CELL_PX;
  localparam int unsigned READ_LAT = 1;

  localparam int unsigned CNT_W    = 10;
  localparam int unsigned COORD_W  = 8;
  localparam int unsigned SUB_W    = $clog2(CELL_PX);
  localparam int unsigned RGB_W    = 8;

  localparam logic [RGB_W-1:0] FG     = 8'hFC;
  localparam logic [RGB_W-1:0] BG     = 8'h00;
  localparam logic [RGB_W-1:0] BORDER = 8'hFF;
  localparam logic [RGB_W-1:0] LINE   = 8'h49;

  localparam logic [1:0] V_ACT  = 2'd0;
  localparam logic [1:0] V_FRP  = 2'd1;
  localparam logic [1:0] V_SYNC = 2'd2;
  localparam logic [1:0] V_BKP  = 2'd3;

  // Per-pixel attributes carried alongside the grid read latency.
  typedef struct packed {
    logic blank;
    logic hs;
    logic vs;
    logic in_grid;
    logic border;
    logic line;
  } pix_flags_t;

endpackage

// File: rtl/grid_vga_renderer_if.sv
// Grid read port between the VGA renderer (master) and the grid storage (slave).
interface grid_vga_renderer_if;
  import tetris_vga_pkg::*;

  logic [COORD_W-1:0] x_coord;
  logic [COORD_W-1:0] y_coord;
  logic               coord_value;
  logic               draw_finish;

  modport master (output x_coord, output y_coord, output draw_finish, input coord_value);
  modport slave  (input x_coord, input y_coord, input draw_finish, output coord_value);
endinterface

// File: rtl/vga_timing_gen.sv
// 640x480@60 counters, vertical state machine, raw sync/active flags and the
// once-per-frame draw_finish strobe at vblank start.
module vga_timing_gen
  import tetris_vga_pkg::*;
(
  input  logic             vga_clk,
  input  logic             rst_n,
  output logic [CNT_W-1:0] h_cnt_o,
  output logic [CNT_W-1:0] v_cnt_o,
  output logic             hs_act_c,
  output logic             vs_act_c,
  output logic             active_c,
  output logic             draw_finish_o
);

  logic [CNT_W-1:0] h_q, h_d;
  logic [CNT_W-1:0] v_q, v_d;
  logic [1:0]       state_q, state_d;
  logic             draw_finish_q, draw_finish_d;

  always_ff @(posedge vga_clk) begin
    if (!rst_n) begin
      h_q           <= '0;
      v_q           <= '0;
      state_q       <= V_ACT;
      draw_finish_q <= 1'b0;
    end else begin
      h_q           <= h_d;
      v_q           <= v_d;
      state_q       <= state_d;
      draw_finish_q <= draw_finish_d;
    end
  end

  // Vertical state only advances on the line wrap, tracking v_cnt regions.
  always_comb begin
    h_d           = CNT_W'(h_q + 1'b1);
    v_d           = v_q;
    state_d       = state_q;
    draw_finish_d = (h_q == '0) && (v_q == CNT_W'(V_ACTIVE));
    if (h_q == CNT_W'(H_TOTAL - 1)) begin
      h_d = '0;
      v_d = (v_q == CNT_W'(V_TOTAL - 1)) ? '0 : CNT_W'(v_q + 1'b1);
      case (state_q)
        V_ACT:   if (v_q == CNT_W'(V_ACTIVE - 1))                 state_d = V_FRP;
        V_FRP:   if (v_q == CNT_W'(V_ACTIVE + V_FP - 1))          state_d = V_SYNC;
        V_SYNC:  if (v_q == CNT_W'(V_ACTIVE + V_FP + V_SYNC_L - 1)) state_d = V_BKP;
        V_BKP:   if (v_q == CNT_W'(V_TOTAL - 1))                  state_d = V_ACT;
        default: state_d = V_ACT;
      endcase
    end
  end

  assign h_cnt_o       = h_q;
  assign v_cnt_o       = v_q;
  assign hs_act_c      = (h_q >= CNT_W'(H_ACTIVE + H_FP)) &&
                         (h_q <  CNT_W'(H_ACTIVE + H_FP + H_SYNC));
  assign vs_act_c      = (state_q == V_SYNC);
  assign active_c      = (h_q < CNT_W'(H_ACTIVE)) && (state_q == V_ACT);
  assign draw_finish_o = draw_finish_q;

endmodule

// File: rtl/grid_vga_renderer.sv
// Grid reader/renderer: maps scan position to grid cells, reads occupancy and
// produces aligned RGB 3-3-2 plus syncs. Define GRID_LINES_EN to draw cell lines.
module grid_vga_renderer
  import tetris_vga_pkg::*;
(
  input  logic               vga_clk,
  input  logic               rst_n,
  grid_vga_renderer_if.master grid,
  output logic               hsync,
  output logic               vsync,
  output logic [RGB_W-1:0]   rgb
);

`ifdef GRID_LINES_EN
  localparam logic LINES_EN = 1'b1;
`else
  localparam logic LINES_EN = 1'b0;
`endif

  logic [CNT_W-1:0] h_cnt, v_cnt;
  logic             hs_act, vs_act, active;

  vga_timing_gen u_timing (
    .vga_clk       (vga_clk),
    .rst_n         (rst_n),
    .h_cnt_o       (h_cnt),
    .v_cnt_o       (v_cnt),
    .hs_act_c      (hs_act),
    .vs_act_c      (vs_act),
    .active_c      (active),
    .draw_finish_o (grid.draw_finish)
  );

  logic [SUB_W-1:0]   sx_q, sx_d, sy_q, sy_d;
  logic [COORD_W-1:0] col_q, col_d, row_q, row_d;
  logic [COORD_W-1:0] x_q, y_q;
  pix_flags_t         flags;
  pix_flags_t         out_f;
  pix_flags_t [READ_LAT:0] pipe_q;
  logic               hsync_q, vsync_q;
  logic [RGB_W-1:0]   rgb_q, rgb_d;
  logic               x_edge, y_edge, x_span, y_span;

  // Cell counters follow h/v; they rest at GRID_W/GRID_H outside the grid.
  always_comb begin
    sx_d  = sx_q;
    col_d = col_q;
    sy_d  = sy_q;
    row_d = row_q;
    if (h_cnt == CNT_W'(X0 - 1)) begin
      sx_d  = '0;
      col_d = '0;
    end else if (col_q < COORD_W'(GRID_W)) begin
      if (sx_q == SUB_W'(CELL_PX - 1)) begin
        sx_d  = '0;
        col_d = COORD_W'(col_q + 1'b1);
      end else begin
        sx_d  = SUB_W'(sx_q + 1'b1);
      end
    end
    if (h_cnt == CNT_W'(H_TOTAL - 1)) begin
      if (v_cnt == CNT_W'(Y0 - 1)) begin
        sy_d  = '0;
        row_d = '0;
      end else if (row_q < COORD_W'(GRID_H)) begin
        if (sy_q == SUB_W'(CELL_PX - 1)) begin
          sy_d  = '0;
          row_d = COORD_W'(row_q + 1'b1);
        end else begin
          sy_d  = SUB_W'(sy_q + 1'b1);
        end
      end
    end
  end

  always_comb begin
    x_edge = (h_cnt == CNT_W'(X0 - 1)) || (h_cnt == CNT_W'(X_END));
    y_edge = (v_cnt == CNT_W'(Y0 - 1)) || (v_cnt == CNT_W'(Y_END));
    x_span = (h_cnt >= CNT_W'(X0 - 1)) && (h_cnt <= CNT_W'(X_END));
    y_span = (v_cnt >= CNT_W'(Y0 - 1)) && (v_cnt <= CNT_W'(Y_END));
    flags         = '0;
    flags.blank   = !active;
    flags.hs      = hs_act;
    flags.vs      = vs_act;
    flags.in_grid = (col_q < COORD_W'(GRID_W)) && (row_q < COORD_W'(GRID_H)) && active;
    flags.border  = active && ((x_edge && y_span) || (y_edge && x_span));
    flags.line    = (sx_q == SUB_W'(CELL_PX - 1)) || (sy_q == SUB_W'(CELL_PX - 1));
  end

  // coord_value arrives READ_LAT cycles after x/y, aligned with the last flag stage.
  always_comb begin
    out_f = pipe_q[READ_LAT];
    rgb_d = '0;
    if (out_f.blank) begin
      rgb_d = '0;
    end else if (out_f.in_grid) begin
      if (LINES_EN && out_f.line) rgb_d = LINE;
      else                        rgb_d = grid.coord_value ? FG : BG;
    end else if (out_f.border) begin
      rgb_d = BORDER;
    end
  end

  always_ff @(posedge vga_clk) begin
    if (!rst_n) begin
      sx_q    <= '0;
      sy_q    <= '0;
      col_q   <= COORD_W'(GRID_W);
      row_q   <= COORD_W'(GRID_H);
      x_q     <= '0;
      y_q     <= '0;
      pipe_q  <= '0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      rgb_q   <= '0;
    end else begin
      sx_q      <= sx_d;
      sy_q      <= sy_d;
      col_q     <= col_d;
      row_q     <= row_d;
      x_q       <= flags.in_grid ? col_q : '0;
      y_q       <= flags.in_grid ? row_q : '0;
      pipe_q[0] <= flags;
      for (int i = 1; i <= int'(READ_LAT); i++) pipe_q[i] <= pipe_q[i-1];
      hsync_q   <= !out_f.hs;
      vsync_q   <= !out_f.vs;
      rgb_q     <= rgb_d;
    end
  end

  assign grid.x_coord = x_q;
  assign grid.y_coord = y_q;
  assign hsync        = hsync_q;
  assign vsync        = vsync_q;
  assign rgb          = rgb_q;

endmodule
